// File: rtl/guess_encoder_if.sv
// Guess interface between the input front end and score_evaluation.
// Handshake: eval_now is a valid-only strobe with no ready; the consumer must
// take user_guess in the single cycle eval_now is high. guess_invalid and
// restart_game are likewise one-cycle, always-accepted event strobes.
interface guess_encoder_if;
   logic [2:0] user_guess;
   logic       eval_now;
   logic       guess_invalid;
   logic       restart_game;

   modport master (
      output user_guess,
      output eval_now,
      output guess_invalid,
      output restart_game
   );

   modport slave (
      input user_guess,
      input eval_now,
      input guess_invalid,
      input restart_game
   );
endinterface

// File: rtl/guess_encoder.sv
// Whack-a-mole input front end: synchronizes and debounces the board buttons
// and bank switch, then turns a single clean direction press into a 3-bit
// guess with a one-cycle eval_now strobe. The centre button gives restart_game.
module guess_encoder #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btnUp,
   input  logic            btnDown,
   input  logic            btnLeft,
   input  logic            btnRight,
   input  logic            btnCenter,
   input  logic            sw,
   guess_encoder_if.master gif,
   output logic            state_dbg
);

   // Input bit order: 0 up, 1 right, 2 down, 3 left, 4 centre, 5 sw.
   // Directions 0..3 line up with their guess encoding.
   localparam int NUM_IN = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, HELD} state_t;

   logic [NUM_IN-1:0] raw;
   logic [NUM_IN-1:0] sync1;
   logic [NUM_IN-1:0] sync2;
   logic [NUM_IN-1:0] level;
   logic [CNT_W-1:0]  cnt [NUM_IN];
   logic [4:0]        prev;
   logic [4:0]        rise;
   logic [3:0]        dirs;
   logic              any_dir_rise;
   logic              single_dir;
   logic              center_rise;
   logic [1:0]        dir_code;
   state_t            state;

   assign raw = {sw, btnCenter, btnLeft, btnDown, btnRight, btnUp};

   // Two-flop synchronizer for every raw input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: level only follows the synced input after it has differed
   // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= '0;
         for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (sync2[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               level[i] <= sync2[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Previous debounced level of the buttons for rise detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev <= '0;
      else      prev <= level[4:0];
   end

   assign rise         = level[4:0] & ~prev;
   assign dirs         = level[3:0];
   assign any_dir_rise = |rise[3:0];
   assign single_dir   = (dirs != 4'b0) && ((dirs & (dirs - 4'd1)) == 4'b0);
   assign center_rise  = rise[4];

   // One-hot direction to guess code; only meaningful when single_dir is set.
   always_comb begin
      dir_code = 2'd0;
      unique case (dirs)
         4'b0001: dir_code = 2'd0;
         4'b0010: dir_code = 2'd1;
         4'b0100: dir_code = 2'd2;
         4'b1000: dir_code = 2'd3;
         default: dir_code = 2'd0;
      endcase
   end

   // Accept FSM with registered strobes. A centre rise coinciding with an
   // accept wins: restart fires, eval_now and the guess update are dropped,
   // and the FSM still waits for full release in HELD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         gif.user_guess    <= '0;
         gif.eval_now      <= 1'b0;
         gif.guess_invalid <= 1'b0;
         gif.restart_game  <= 1'b0;
      end else begin
         gif.eval_now      <= 1'b0;
         gif.guess_invalid <= 1'b0;
         gif.restart_game  <= center_rise;
         unique case (state)
            IDLE: begin
               if (any_dir_rise) begin
                  state <= HELD;
                  if (!single_dir) begin
                     gif.guess_invalid <= 1'b1;
                  end else if (!center_rise) begin
                     gif.user_guess <= {level[5], dir_code};
                     gif.eval_now   <= 1'b1;
                  end
               end
            end
            HELD: begin
               if (dirs == 4'b0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign state_dbg = (state == HELD);

endmodule

// File: tb/tb_guess_encoder.sv
// Directed bench for guess_encoder with a short debounce window.
module tb_guess_encoder;

   localparam int DC  = 4;
   localparam int LAT = DC + 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0;
   logic btnRight = 1'b0, btnCenter = 1'b0, sw = 1'b0;
   logic state_dbg;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int eval_cnt  = 0;
   int inv_cnt   = 0;
   int rst_cnt   = 0;
   int dbl_cnt   = 0;
   logic eval_d = 1'b0, inv_d = 1'b0, rg_d = 1'b0;

   guess_encoder_if gif ();

   guess_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .btnUp     (btnUp),
      .btnDown   (btnDown),
      .btnLeft   (btnLeft),
      .btnRight  (btnRight),
      .btnCenter (btnCenter),
      .sw        (sw),
      .gif       (gif),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Strobe counters and back-to-back strobe detection
   always @(posedge clk) begin
      if (gif.eval_now)      eval_cnt <= eval_cnt + 1;
      if (gif.guess_invalid) inv_cnt  <= inv_cnt + 1;
      if (gif.restart_game)  rst_cnt  <= rst_cnt + 1;
      if ((gif.eval_now && eval_d) || (gif.guess_invalid && inv_d) ||
          (gif.restart_game && rg_d))
         dbl_cnt <= dbl_cnt + 1;
      eval_d <= gif.eval_now;
      inv_d  <= gif.guess_invalid;
      rg_d   <= gif.restart_game;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait up to limit cycles for a strobe (0 eval, 1 invalid, 2 restart);
   // lat is cycles since the call, or -1 on timeout.
   task automatic wait_strobe(input int which, input int limit, output int lat);
      lat = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk);
         #1;
         if ((which == 0 && gif.eval_now) || (which == 1 && gif.guess_invalid) ||
             (which == 2 && gif.restart_game)) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int e0, i0, r0;
      int seen;

      // Reset
      step(3);
      check("reset_guess", gif.user_guess, 0);
      check("reset_eval", gif.eval_now, 0);
      check("reset_invalid", gif.guess_invalid, 0);
      check("reset_restart", gif.restart_game, 0);
      check("reset_state", state_dbg, 0);
      rst = 1'b1;
      step(3);

      // 1: hold right, sw=0; exact latency and a single strobe
      e0 = eval_cnt;
      btnRight = 1'b1;
      seen = -1;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (gif.eval_now) begin
            if (seen == -1) seen = i;
         end
      end
      check("t1_latency", seen, LAT);
      check("t1_guess", gif.user_guess, 1);
      check("t1_eval_count", eval_cnt - e0, 1);
      check("t1_held_state", state_dbg, 1);
      btnRight = 1'b0;
      step(10);
      check("t1_release_idle", state_dbg, 0);

      // 2: bank 1, left then up after left release has debounced
      sw = 1'b1;
      step(10);
      btnLeft = 1'b1;
      wait_strobe(0, 20, lat);
      check("t2_left_latency", lat, LAT);
      check("t2_left_guess", gif.user_guess, 7);
      step(3);
      btnLeft = 1'b0;
      step(2);
      btnUp = 1'b1;
      wait_strobe(0, 20, lat);
      check("t2_up_latency", lat, LAT);
      check("t2_up_guess", gif.user_guess, 4);
      step(3);
      btnUp = 1'b0;
      step(10);

      // 3: bouncing down press, then a too-short pulse
      sw = 1'b0;
      step(10);
      e0 = eval_cnt;
      for (int b = 0; b < 5; b++) begin
         btnDown = 1'b1;
         step(2);
         btnDown = 1'b0;
         step(2);
      end
      btnDown = 1'b1;
      step(20);
      check("t3_bounce_eval_count", eval_cnt - e0, 1);
      check("t3_bounce_guess", gif.user_guess, 2);
      btnDown = 1'b0;
      step(10);
      e0 = eval_cnt;
      btnDown = 1'b1;
      step(3);
      btnDown = 1'b0;
      step(15);
      check("t3_glitch_eval_count", eval_cnt - e0, 0);
      check("t3_glitch_guess", gif.user_guess, 2);

      // 4: two directions together are rejected
      e0 = eval_cnt;
      i0 = inv_cnt;
      btnUp   = 1'b1;
      btnDown = 1'b1;
      wait_strobe(1, 20, lat);
      check("t4_invalid_latency", lat, LAT);
      step(1);
      check("t4_invalid_one_cycle", gif.guess_invalid, 0);
      step(5);
      check("t4_invalid_count", inv_cnt - i0, 1);
      check("t4_no_eval", eval_cnt - e0, 0);
      check("t4_guess_kept", gif.user_guess, 2);
      btnUp   = 1'b0;
      btnDown = 1'b0;
      step(10);
      btnUp = 1'b1;
      wait_strobe(0, 20, lat);
      check("t4_up_latency", lat, LAT);
      check("t4_up_guess", gif.user_guess, 0);
      btnUp = 1'b0;
      step(10);

      // 5: centre and right together -> restart only
      e0 = eval_cnt;
      r0 = rst_cnt;
      btnCenter = 1'b1;
      btnRight  = 1'b1;
      wait_strobe(2, 20, lat);
      check("t5_restart_latency", lat, LAT);
      step(1);
      check("t5_restart_one_cycle", gif.restart_game, 0);
      step(5);
      check("t5_restart_count", rst_cnt - r0, 1);
      check("t5_eval_suppressed", eval_cnt - e0, 0);
      check("t5_held_state", state_dbg, 1);
      btnCenter = 1'b0;
      btnRight  = 1'b0;
      step(10);
      btnRight = 1'b1;
      wait_strobe(0, 20, lat);
      check("t5_right_latency", lat, LAT);
      check("t5_right_guess", gif.user_guess, 1);
      btnRight = 1'b0;
      step(10);

      // 6: async reset in the middle of a held left press
      btnLeft = 1'b1;
      wait_strobe(0, 20, lat);
      check("t6_first_guess", gif.user_guess, 3);
      step(3);
      rst = 1'b0;
      #1;
      check("t6_async_guess", gif.user_guess, 0);
      check("t6_async_state", state_dbg, 0);
      check("t6_async_eval", gif.eval_now, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_strobe(0, 20, lat);
      check("t6_rearm_latency", lat, LAT);
      check("t6_rearm_guess", gif.user_guess, 3);
      btnLeft = 1'b0;
      step(10);

      check("no_back_to_back_strobes", dbl_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
